// File: rtl/foc_hls_deadlock_reporter.sv
// Deadlock reporter: counts consecutive blocked cycles and emits one report word.
// Define DEADLOCK_TIMESTAMP_EN to prepend a free-running timestamp to the report.
module foc_hls_deadlock_reporter #(
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = 16,
    parameter int TS_W      = 32,
`ifdef DEADLOCK_TIMESTAMP_EN
    localparam int DW       = 3 + CNT_W + TS_W
`else
    localparam int DW       = 3 + CNT_W + 0 * TS_W
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             block,
    input  logic [2:0]       axis_block_sigs,
    input  logic             clear,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [DW-1:0]    report_data,
    output logic             deadlock,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        REPORT,
        LATCHED
    } state_t;

    localparam logic [CNT_W-1:0] TH = CNT_W'(THRESHOLD);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             capture;

`ifdef DEADLOCK_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ts_q <= '0;
        else          ts_q <= ts_q + TS_W'(1);
    end
`endif

    // Saturating increment; the count never wraps back to zero.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (block) begin
                    cnt_d = CNT_W'(1);
                    if (THRESHOLD == 1) begin
                        state_d = REPORT;
                        capture = 1'b1;
                    end else begin
                        state_d = COUNT;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            COUNT: begin
                if (!block || clear) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TH) begin
                        state_d = REPORT;
                        capture = 1'b1;
                    end
                end
            end
            REPORT: begin
                if (report_ready) state_d = LATCHED;
            end
            LATCHED: begin
                if (clear) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            report_data <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
`ifdef DEADLOCK_TIMESTAMP_EN
                report_data <= {ts_q, cnt_d, axis_block_sigs};
`else
                report_data <= {cnt_d, axis_block_sigs};
`endif
            end
        end
    end

    assign report_valid = (state_q == REPORT);
    assign deadlock     = (state_q == REPORT) || (state_q == LATCHED);
    assign stall_count  = cnt_q;

endmodule

// File: tb/tb_foc_hls_deadlock_reporter.sv
// Randomized bench for the deadlock reporter, two instances (threshold 16 and 1)
// checked every cycle against a run-length reference model.
module tb_foc_hls_deadlock_reporter;

    localparam int CNT_W = 16;
    localparam int TS_W  = 32;
`ifdef DEADLOCK_TIMESTAMP_EN
    localparam int DW = 3 + CNT_W + TS_W;
`else
    localparam int DW = 3 + CNT_W;
`endif

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             block = 1'b0;
    logic [2:0]       axis_block_sigs = 3'b000;
    logic             clear = 1'b0;
    logic             report_ready = 1'b0;

    logic             rv0, dl0, rv1, dl1;
    logic [DW-1:0]    rd0, rd1;
    logic [CNT_W-1:0] sc0, sc1;

    always #5 clock = ~clock;

    foc_hls_deadlock_reporter #(
        .THRESHOLD(16), .CNT_W(CNT_W), .TS_W(TS_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .block(block),
        .axis_block_sigs(axis_block_sigs), .clear(clear),
        .report_valid(rv0), .report_ready(report_ready),
        .report_data(rd0), .deadlock(dl0), .stall_count(sc0)
    );

    foc_hls_deadlock_reporter #(
        .THRESHOLD(1), .CNT_W(CNT_W), .TS_W(TS_W)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .block(block),
        .axis_block_sigs(axis_block_sigs), .clear(clear),
        .report_valid(rv1), .report_ready(report_ready),
        .report_data(rd1), .deadlock(dl1), .stall_count(sc1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: length of the current blocked run, plus report/latched flags.
    int            th[2] = '{16, 1};
    int            m_run[2];
    bit            m_rep[2];
    bit            m_lat[2];
    logic [DW-1:0] m_data[2];
    longint        m_ts;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i]  = 0;
            m_rep[i]  = 0;
            m_lat[i]  = 0;
            m_data[i] = '0;
        end
        m_ts = 0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (m_rep[i]) begin
                if (report_ready) begin
                    m_rep[i] = 0;
                    m_lat[i] = 1;
                end
            end else if (m_lat[i]) begin
                if (clear) begin
                    m_lat[i] = 0;
                    m_run[i] = 0;
                end
            end else if (!block || (clear && m_run[i] > 0)) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] == th[i]) begin
                    m_rep[i] = 1;
`ifdef DEADLOCK_TIMESTAMP_EN
                    m_data[i] = {TS_W'(m_ts), CNT_W'(m_run[i]), axis_block_sigs};
`else
                    m_data[i] = {CNT_W'(m_run[i]), axis_block_sigs};
`endif
                end
            end
        end
        m_ts++;
    endtask

    task automatic check_outputs();
        check("valid0", rv0, m_rep[0]);
        check("deadlock0", dl0, m_rep[0] | m_lat[0]);
        check("count0", sc0, m_run[0]);
        if (m_rep[0]) check("data0", rd0, m_data[0]);
        check("valid1", rv1, m_rep[1]);
        check("deadlock1", dl1, m_rep[1] | m_lat[1]);
        check("count1", sc1, m_run[1]);
        if (m_rep[1]) check("data1", rd1, m_data[1]);
    endtask

    task automatic cycle(input bit b, input logic [2:0] ax,
                         input bit rdy, input bit clr);
        block           = b;
        axis_block_sigs = ax;
        report_ready    = rdy;
        clear           = clr;
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid0", rv0, 0);
        check("rst_deadlock0", dl0, 0);
        check("rst_count0", sc0, 0);
        check("rst_data0", rd0, 0);
        check("rst_valid1", rv1, 0);
        check("rst_deadlock1", dl1, 0);
        repeat (2) @(posedge clock);
        #1;
        block = 1'b0;
        clear = 1'b0;
        report_ready = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic rearm();
        cycle(0, 3'b000, 1, 0);
        cycle(0, 3'b000, 0, 1);
    endtask

    logic [DW-1:0] snap;
    int            p;

    initial begin
        do_reset();

        repeat (15) cycle(1, 3'b000, 0, 0);
        check("run15", sc0, 15);
        cycle(0, 3'b000, 0, 0);
        check("run_drop", sc0, 0);
        check("no_report", rv0, 0);

        rearm();
        repeat (16) cycle(1, 3'b101, 0, 0);
        snap = rd0;
        check("hit_valid", rv0, 1);
        check("hit_deadlock", dl0, 1);
        check("hit_mask", snap[2:0], 3'b101);
        check("hit_count", snap[3 +: CNT_W], 16);

        repeat (10) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom), 0,
                  1'($urandom_range(0, 1)));
            check("hold_data", rd0, snap);
            check("hold_valid", rv0, 1);
        end
        cycle(0, 3'b000, 1, 0);
        check("latched_valid", rv0, 0);
        check("latched_deadlock", dl0, 1);
        cycle(1, 3'b000, 0, 0);
        check("latched_block", dl0, 1);
        cycle(0, 3'b000, 0, 1);
        check("clear_deadlock", dl0, 0);
        check("clear_count", sc0, 0);

        rearm();
        cycle(1, 3'b010, 0, 0);
        snap = rd1;
        check("th1_valid", rv1, 1);
        check("th1_count", snap[3 +: CNT_W], 1);
        check("th1_mask", snap[2:0], 3'b010);
        cycle(0, 3'b000, 0, 0);
        check("th1_hold", rv1, 1);

        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) p = ($urandom_range(0, 1) != 0) ? 97 : 40;
            cycle(1'($urandom_range(0, 99) < p), 3'($urandom),
                  1'($urandom_range(0, 99) < 25),
                  1'($urandom_range(0, 99) < 6));
        end

        rearm();
        repeat (16) cycle(1, 3'($urandom), 0, 0);
        check("pre_reset_valid", rv0, 1);
        do_reset();

        repeat (100) cycle(0, 3'b000, 0, 0);
        repeat (16) cycle(1, 3'b011, 0, 0);
        check("ts_valid", rv0, 1);
        snap = rd0;
        check("ts_mask", snap[2:0], 3'b011);
`ifdef DEADLOCK_TIMESTAMP_EN
        check("ts_value", snap[3 + CNT_W +: TS_W], 115);
`endif
        cycle(0, 3'b000, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/foc_hls_deadlock_reporter.md
FOC_HLS_DEADLOCK_REPORTER -- requirements
Module: foc_hls_deadlock_reporter

Interface
REQ-001 SHALL have parameter THRESHOLD, default 16: consecutive blocked cycles that declare a deadlock; legal range 1 to 2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-003 SHALL have parameter TS_W, default 32: timestamp width, used only under REQ-024.
REQ-004 SHALL have port clock, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port block, input, 1: registered block flag from the deadlock monitor.
REQ-007 SHALL have port axis_block_sigs, input, 3: per-AXIS-channel block indications.
REQ-008 SHALL have port clear, input, 1: single-cycle pulse that re-arms the reporter.
REQ-009 SHALL have port report_valid, output, 1: report word available.
REQ-010 SHALL have port report_ready, input, 1: downstream accepts the report.
REQ-011 SHALL have port report_data, output, 3+CNT_W: {stall count[CNT_W-1:0], channel mask[2:0]}; 3+CNT_W+TS_W under REQ-024, timestamp in the MSBs.
REQ-012 SHALL have port deadlock, output, 1: sticky deadlock indication.
REQ-013 SHALL have port stall_count, output, CNT_W: live consecutive-block count.

Function
REQ-014 SHALL implement a 4-state FSM: IDLE, COUNT, REPORT, LATCHED.
REQ-015 IDLE: block=1 -> stall_count<=1; next state REPORT when THRESHOLD==1, otherwise COUNT; block=0 -> stay, stall_count<=0.
REQ-016 COUNT: block=0 or clear=1 -> IDLE, stall_count<=0; block=1 -> stall_count+1; the cycle the count reaches THRESHOLD -> REPORT.
REQ-017 On REPORT entry SHALL capture axis_block_sigs and the count (==THRESHOLD) into report_data, assert report_valid and assert deadlock, all in the cycle after the edge that samples the THRESHOLD-th consecutive block=1.
REQ-018 REPORT: report_valid held high and report_data held stable until report_valid&&report_ready; block deasserting or clear does not drop report_valid; on handshake -> LATCHED.
REQ-019 LATCHED: report_valid=0, deadlock=1; clear=1 -> IDLE with deadlock<=0 and stall_count<=0; block ignored.
REQ-020 stall_count SHALL freeze in REPORT/LATCHED and never wrap (saturate at all-ones).
REQ-021 report_ready SHALL be ignored outside REPORT; clear SHALL be ignored in IDLE and REPORT.

Reset
REQ-022 reset_n=0 SHALL asynchronously force IDLE, report_valid=0, deadlock=0, stall_count=0, report_data=0, timestamp=0; applies mid-report (an outstanding report is discarded).
REQ-023 Outputs SHALL leave reset values only on a rising clock edge after reset_n deasserts.

Configuration
REQ-024 With DEADLOCK_TIMESTAMP_EN defined: a free-running TS_W-bit counter (wraps, cleared by reset) SHALL be captured into report_data[3+CNT_W+TS_W-1:3+CNT_W] on REPORT entry; without it, no counter exists and report_data is 3+CNT_W bits.

Verification
REQ-025 THRESHOLD=16, block high 15 cycles then low -> no report_valid; stall_count returns to 0 next cycle.
REQ-026 THRESHOLD=16, block high 16 cycles, axis_block_sigs=3'b101 -> report_valid and deadlock high the next cycle, report_data[2:0]=3'b101, count field=16.
REQ-027 REPORT with report_ready low 10 cycles then high 1 cycle -> report_data stable throughout; LATCHED, deadlock stays 1; clear pulse -> deadlock 0 next cycle.
REQ-028 THRESHOLD=1, single-cycle block pulse -> report_valid next cycle, count field=1.
REQ-029 reset_n low asynchronously while in REPORT -> report_valid and deadlock 0 without a clock edge; with DEADLOCK_TIMESTAMP_EN defined, a report after 100 cycles out of reset carries the correct timestamp.
